// File: rtl/memory_access_unit.sv
// memory_access_unit
// Memory-stage access engine. Takes the EX/MEM register outputs (address,
// store data, byte format, extension mode) and turns them into word-aligned,
// byte-enabled beats on a req/ack data-memory bus. Accesses that straddle a
// word boundary are split into two beats. Load bytes are merged back,
// right-aligned and sign/zero-extended. The pipeline is stalled until the
// access completes.
//
// Ports
//   clk, rst_n_i        clock, asynchronous active-low reset
//   ALU_outM_i          byte address of the access
//   WriteDataM_i        right-aligned store data
//   MemWriteM_i         store request (wins over MemReadM_i)
//   MemReadM_i          load request
//   ByteSelectM_i       00 byte, 01 half, 10/11 word
//   MemExtendM_i        1 sign-extend, 0 zero-extend (byte/half loads)
//   StallM_o            hold M and earlier stages
//   ReadDataM_o         extended load result, holds outside DONE
//   ReadValidM_o        one-cycle load completion pulse
//   ErrorM_o            sticky ack-timeout flag
//   mem_req_o/we/addr/be/wdata, mem_ack_i, mem_rdata_i   data-memory bus
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a load/store; latches the request
// BEAT0 | first (or only) beat on the bus, word at addr & ~3
// BEAT1 | second beat of a split access, word at (addr & ~3) + 4
// DONE  | access finished; stall released, load result valid
module memory_access_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] ALU_outM_i,
  input  logic [DATA_WIDTH-1:0] WriteDataM_i,
  input  logic                  MemWriteM_i,
  input  logic                  MemReadM_i,
  input  logic [1:0]            ByteSelectM_i,
  input  logic                  MemExtendM_i,
  output logic                  StallM_o,
  output logic [DATA_WIDTH-1:0] ReadDataM_o,
  output logic                  ReadValidM_o,
  output logic                  ErrorM_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  ext_q, ext_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            full_be_q, full_be_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  in_beat;
  logic                  split;
  logic [3:0]            lo_mask;
  logic [3:0]            beat_be;
  logic [3:0]            base_be;
  logic [DATA_WIDTH-1:0] merged_now;
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] ext_val;

  // Byte lane k of the access maps to bus lane (off + k) mod 4.
  function automatic logic [31:0] rotl_lanes(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    rotl_lanes = d;
      2'd1:    rotl_lanes = {d[23:0], d[31:24]};
      2'd2:    rotl_lanes = {d[15:0], d[31:16]};
      default: rotl_lanes = {d[7:0],  d[31:8]};
    endcase
  endfunction

  function automatic logic [31:0] rotr_lanes(input logic [31:0] d, input logic [1:0] k);
    case (k)
      2'd0:    rotr_lanes = d;
      2'd1:    rotr_lanes = {d[7:0],  d[31:8]};
      2'd2:    rotr_lanes = {d[15:0], d[31:16]};
      default: rotr_lanes = {d[23:0], d[31:24]};
    endcase
  endfunction

  function automatic logic [3:0] rotl_be(input logic [3:0] b, input logic [1:0] k);
    case (k)
      2'd0:    rotl_be = b;
      2'd1:    rotl_be = {b[2:0], b[3]};
      2'd2:    rotl_be = {b[1:0], b[3:2]};
      default: rotl_be = {b[0],   b[3:1]};
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    lane_mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // Enables of the whole access are rotated by the offset; lanes at or above
  // the offset belong to beat0, lanes that wrapped below it belong to beat1.
  always_comb begin
    lo_mask    = 4'b1111 << off_q;
    split      = |(full_be_q & ~lo_mask);
    in_beat    = (state_q == BEAT0) || (state_q == BEAT1);
    beat_be    = (state_q == BEAT1) ? (full_be_q & ~lo_mask) : (full_be_q & lo_mask);
    merged_now = (acc_q & ~lane_mask(beat_be)) | (mem_rdata_i & lane_mask(beat_be));
    load_val   = rotr_lanes(merged_now, off_q);
    case (size_q)
      2'b00:   ext_val = {{24{ext_q & load_val[7]}},  load_val[7:0]};
      2'b01:   ext_val = {{16{ext_q & load_val[15]}}, load_val[15:0]};
      default: ext_val = load_val;
    endcase
    case (ByteSelectM_i)
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    we_d         = we_q;
    ext_d        = ext_q;
    wdata_d      = wdata_q;
    full_be_d    = full_be_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    StallM_o     = 1'b0;
    ReadValidM_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWriteM_i || MemReadM_i) begin
          StallM_o  = 1'b1;
          addr_d    = {ALU_outM_i[ADDR_WIDTH-1:2], 2'b00};
          off_d     = ALU_outM_i[1:0];
          size_d    = ByteSelectM_i;
          we_d      = MemWriteM_i;
          ext_d     = MemExtendM_i;
          wdata_d   = rotl_lanes(WriteDataM_i, ALU_outM_i[1:0]);
          full_be_d = rotl_be(base_be, ALU_outM_i[1:0]);
          cnt_d     = '0;
          acc_d     = '0;
          state_d   = BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        StallM_o = 1'b1;
        if (mem_ack_i) begin
          acc_d = merged_now;
          cnt_d = '0;
          if ((state_q == BEAT0) && split) begin
            state_d = BEAT1;
          end else begin
            state_d = DONE;
            if (!we_q) rdata_d = ext_val;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the access, including any beat not yet issued.
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        ReadValidM_o = !we_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      ext_q     <= 1'b0;
      wdata_q   <= '0;
      full_be_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      size_q    <= size_d;
      we_q      <= we_d;
      ext_q     <= ext_d;
      wdata_q   <= wdata_d;
      full_be_q <= full_be_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Bus outputs are decoded from state so that reset removes req at once.
  assign mem_req_o   = in_beat;
  assign mem_we_o    = in_beat & we_q;
  assign mem_addr_o  = !in_beat ? '0 :
                       (state_q == BEAT1) ? addr_q + ADDR_WIDTH'(4) : addr_q;
  assign mem_be_o    = in_beat ? beat_be : 4'b0000;
  assign mem_wdata_o = (in_beat && we_q) ? (wdata_q & lane_mask(beat_be)) : '0;
  assign ReadDataM_o = rdata_q;
  assign ErrorM_o    = err_q;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b1;
  logic [31:0] ALU_outM_i = '0;
  logic [31:0] WriteDataM_i = '0;
  logic        MemWriteM_i = 1'b0;
  logic        MemReadM_i = 1'b0;
  logic [1:0]  ByteSelectM_i = '0;
  logic        MemExtendM_i = 1'b0;
  logic        StallM_o;
  logic [31:0] ReadDataM_o;
  logic        ReadValidM_o;
  logic        ErrorM_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  always #5 clk = ~clk;

  memory_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .ALU_outM_i(ALU_outM_i), .WriteDataM_i(WriteDataM_i),
    .MemWriteM_i(MemWriteM_i), .MemReadM_i(MemReadM_i),
    .ByteSelectM_i(ByteSelectM_i), .MemExtendM_i(MemExtendM_i),
    .StallM_o(StallM_o), .ReadDataM_o(ReadDataM_o), .ReadValidM_o(ReadValidM_o),
    .ErrorM_o(ErrorM_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] res_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  int          wait_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: acks a requested beat after ack_delay wait cycles using the
  // next expected beat; with nothing queued the bus never acks.
  always @(negedge clk) begin
    beat_t b;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    if (mem_req_o && beat_q.size() > 0) begin
      if (wait_n >= ack_delay) begin
        b = beat_q.pop_front();
        check("bus_addr", mem_addr_o, b.addr);
        check("bus_we", {31'd0, mem_we_o}, {31'd0, b.we});
        check("bus_be", {28'd0, mem_be_o}, {28'd0, b.be});
        check("bus_wdata", mem_wdata_o, b.wdata);
        mem_ack_i   = 1'b1;
        mem_rdata_i = b.rdata;
        wait_n      = 0;
      end else begin
        wait_n++;
      end
    end else begin
      wait_n = 0;
    end
  end

  task automatic push_beat(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    beat_t b;
    b.addr = addr; b.we = we; b.be = be; b.wdata = wdata; b.rdata = rdata;
    beat_q.push_back(b);
  endtask

  task automatic do_access(input string tag, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] bsel, input logic ext, input int exp_stall);
    int          stall_n = 0;
    bit          done = 0;
    logic [31:0] exp_res;
    @(negedge clk);
    ALU_outM_i = addr; WriteDataM_i = wdata; MemWriteM_i = wr; MemReadM_i = rd;
    ByteSelectM_i = bsel; MemExtendM_i = ext;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (!StallM_o) done = 1;
      else begin
        stall_n++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_stall"}, stall_n, exp_stall);
    check({tag, "_valid"}, {31'd0, ReadValidM_o}, {31'd0, rd & ~wr});
    if (ReadValidM_o) begin
      if (res_q.size() > 0) begin
        exp_res = res_q.pop_front();
        check({tag, "_rdata"}, ReadDataM_o, exp_res);
      end else begin
        check({tag, "_res_queue"}, 32'd0, 32'd1);
      end
    end
    MemWriteM_i = 1'b0; MemReadM_i = 1'b0; WriteDataM_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {23'd0, StallM_o, ReadValidM_o, ErrorM_o, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
    check({tag, "_addr"}, mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_rdata"}, ReadDataM_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    #2 rst_n_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n_i = 1'b1;

    // 1: aligned word load, ack three cycles late
    ack_delay = 3;
    push_beat(32'h100, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF);
    res_q.push_back(32'hDEADBEEF);
    do_access("t1_word_ld", 1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 5);
    ack_delay = 0;

    // 2: byte loads from lane 3, signed and unsigned
    push_beat(32'h100, 1'b0, 4'b1000, 32'h0, 32'h80123456);
    res_q.push_back(32'hFFFFFF80);
    do_access("t2_byte_sx", 1'b0, 1'b1, 32'h103, 32'h0, 2'b00, 1'b1, 2);
    push_beat(32'h100, 1'b0, 4'b1000, 32'h0, 32'h80123456);
    res_q.push_back(32'h00000080);
    do_access("t2_byte_zx", 1'b0, 1'b1, 32'h103, 32'h0, 2'b00, 1'b0, 2);

    // aligned-in-word half load at offset 2, sign-extended
    push_beat(32'h100, 1'b0, 4'b1100, 32'h0, 32'h9ABC0000);
    res_q.push_back(32'hFFFF9ABC);
    do_access("half_ld_off2", 1'b0, 1'b1, 32'h102, 32'h0, 2'b01, 1'b1, 2);

    // 3: split half store at offset 3, upper data bits must not leak
    push_beat(32'h200, 1'b1, 4'b1000, 32'hCD000000, 32'h0);
    push_beat(32'h204, 1'b1, 4'b0001, 32'h000000AB, 32'h0);
    do_access("t3_half_st", 1'b1, 1'b0, 32'h203, 32'h1234ABCD, 2'b01, 1'b0, 3);

    // byte store in lane 1
    push_beat(32'h0, 1'b1, 4'b0010, 32'h00005A00, 32'h0);
    do_access("byte_st", 1'b1, 1'b0, 32'h1, 32'hFFFFFF5A, 2'b00, 1'b0, 2);

    // split word store at offset 1
    push_beat(32'h104, 1'b1, 4'b1110, 32'h22334400, 32'h0);
    push_beat(32'h108, 1'b1, 4'b0001, 32'h00000011, 32'h0);
    do_access("word_st_off1", 1'b1, 1'b0, 32'h105, 32'h11223344, 2'b10, 1'b0, 3);

    // read and write together: the write wins, no load pulse
    push_beat(32'h300, 1'b1, 4'b1111, 32'h0BADF00D, 32'h0);
    do_access("wr_and_rd", 1'b1, 1'b1, 32'h300, 32'h0BADF00D, 2'b10, 1'b0, 2);

    // 4: split word load wrapping past the top of the address space
    push_beat(32'hFFFFFFFC, 1'b0, 4'b1100, 32'h0, 32'h11225566);
    push_beat(32'h00000000, 1'b0, 4'b0011, 32'h0, 32'h77883344);
    res_q.push_back(32'h33441122);
    do_access("t4_wrap_ld", 1'b0, 1'b1, 32'hFFFFFFFE, 32'h0, 2'b10, 1'b0, 3);

    // ByteSelect 11 behaves as word and ignores MemExtend
    push_beat(32'h400, 1'b0, 4'b1111, 32'h0, 32'h80000001);
    res_q.push_back(32'h80000001);
    do_access("bsel11_ld", 1'b0, 1'b1, 32'h400, 32'h0, 2'b11, 1'b1, 2);
    check("err_before_timeout", {31'd0, ErrorM_o}, 32'd0);

    // 5: no ack at all -> 16 request cycles, error, zero result
    res_q.push_back(32'h0);
    do_access("t5_timeout", 1'b0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b0, 17);
    check("t5_req_dropped", {31'd0, mem_req_o}, 32'd0);
    check("t5_err_set", {31'd0, ErrorM_o}, 32'd1);
    push_beat(32'h44, 1'b0, 4'b1111, 32'h0, 32'h12345678);
    res_q.push_back(32'h12345678);
    do_access("t5_after", 1'b0, 1'b1, 32'h44, 32'h0, 2'b10, 1'b0, 2);
    check("t5_err_sticky", {31'd0, ErrorM_o}, 32'd1);

    // 6: reset asserted while the second beat is pending
    push_beat(32'h100, 1'b0, 4'b1110, 32'h0, 32'hAABBCC00);
    @(negedge clk);
    ALU_outM_i = 32'h101; MemReadM_i = 1'b1; ByteSelectM_i = 2'b10; MemExtendM_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t6_in_beat1_req", {31'd0, mem_req_o}, 32'd1);
    check("t6_in_beat1_addr", mem_addr_o, 32'h104);
    rst_n_i = 1'b0;
    MemReadM_i = 1'b0;
    #1;
    check_all_zero("t6_reset");
    @(negedge clk);
    rst_n_i = 1'b1;
    push_beat(32'h300, 1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);
    res_q.push_back(32'hCAFEF00D);
    do_access("t6_fresh", 1'b0, 1'b1, 32'h300, 32'h0, 2'b10, 1'b0, 2);

    check("beats_left", beat_q.size(), 32'd0);
    check("results_left", res_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
